// File: rtl/ilb_stream_reader.sv
// Input-line-buffer reader: pulls a burst of beats from the ILB under ready/valid
// and holds each beat in an output register until the SoP datapath consumes it.
module ilb_stream_reader #(
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned NUM_BYTES = 6,
  parameter int unsigned BEATS_W   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ilb_read_enable,
  input  logic [BEATS_W-1:0]            beat_count,
  input  logic                          flush,
  input  logic                          sop_to_ilb_rts,
  output logic                          sop_to_ilb_rtr,
  input  logic [NUM_BYTES*BYTE_W-1:0]   ilb_bytes,
  output logic [NUM_BYTES*BYTE_W-1:0]   out_bytes,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned DataW = NUM_BYTES * BYTE_W;
  localparam logic [BEATS_W-1:0] OneBeat = BEATS_W'(1);

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  state_e              state_q;
  logic [BEATS_W-1:0]  beats_left_q;
  logic [DataW-1:0]    out_bytes_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic                done_q;
  logic                xfer;
  logic                consume;

  // Accept a new beat only when the output register is empty or being drained.
  assign sop_to_ilb_rtr = (state_q == StActive) && (!out_valid_q || out_ready);
  assign xfer           = sop_to_ilb_rts && sop_to_ilb_rtr;
  assign consume        = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      beats_left_q <= '0;
      out_bytes_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A flush coincident with a start request drops the request.
          if (ilb_read_enable && !flush) begin
            beats_left_q <= (beat_count == '0) ? OneBeat : beat_count;
            state_q      <= StActive;
          end
        end
        StActive: begin
          if (flush) begin
            state_q      <= StIdle;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            beats_left_q <= '0;
          end else if (xfer) begin
            out_bytes_q  <= ilb_bytes;
            out_valid_q  <= 1'b1;
            out_last_q   <= (beats_left_q == OneBeat);
            beats_left_q <= beats_left_q - OneBeat;
            if (beats_left_q == OneBeat) begin
              state_q <= StDrain;
            end
          end else if (consume) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        StDrain: begin
          if (flush) begin
            state_q      <= StIdle;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            beats_left_q <= '0;
          end else if (consume) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_bytes = out_bytes_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ilb_stream_reader.sv
// Directed bench for ilb_stream_reader: cycle table for bursts/flush/zero-length,
// plus sequences for backpressure, reset mid-burst and a wide-parameter burst.
module tb_ilb_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Default-parameter instance
  logic         en1, flush1, rts1, rtr1, ready1, valid1, last1, busy1, done1;
  logic [2:0]   cnt1;
  logic [47:0]  ilb1, out1;

  // Wide-parameter instance
  logic         en2, flush2, rts2, rtr2, ready2, valid2, last2, busy2, done2;
  logic [3:0]   cnt2;
  logic [143:0] ilb2, out2;

  ilb_stream_reader u_dut1 (
    .clk(clk), .rst(rst), .ilb_read_enable(en1), .beat_count(cnt1), .flush(flush1),
    .sop_to_ilb_rts(rts1), .sop_to_ilb_rtr(rtr1), .ilb_bytes(ilb1), .out_bytes(out1),
    .out_valid(valid1), .out_last(last1), .out_ready(ready1), .busy(busy1), .done(done1)
  );

  ilb_stream_reader #(.BYTE_W(16), .NUM_BYTES(9), .BEATS_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .ilb_read_enable(en2), .beat_count(cnt2), .flush(flush2),
    .sop_to_ilb_rts(rts2), .sop_to_ilb_rtr(rtr2), .ilb_bytes(ilb2), .out_bytes(out2),
    .out_valid(valid2), .out_last(last2), .out_ready(ready2), .busy(busy2), .done(done2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          en;
    logic [2:0]  cnt;
    bit          fl;
    bit          rts;
    bit          rdy;
    logic [47:0] data;
    bit          e_rtr;
    bit          e_valid;
    bit          e_last;
    bit          e_busy;
    bit          e_done;
    logic [47:0] e_bytes;
  } vec_t;

  function automatic vec_t mk(bit en, logic [2:0] cnt, bit fl, bit rts, bit rdy,
                              logic [47:0] d, bit rtr, bit v, bit l, bit b, bit dn,
                              logic [47:0] eb);
    vec_t r;
    r.en = en; r.cnt = cnt; r.fl = fl; r.rts = rts; r.rdy = rdy; r.data = d;
    r.e_rtr = rtr; r.e_valid = v; r.e_last = l; r.e_busy = b; r.e_done = dn;
    r.e_bytes = eb;
    return r;
  endfunction

  function automatic logic [143:0] mk2(int b);
    logic [143:0] r;
    for (int k = 0; k < 9; k++) r[k*16 +: 16] = 16'((b + 1) * 256 + k * 17);
    return r;
  endfunction

  localparam logic [47:0] D1 = 48'h010203040506, D2 = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] D3 = 48'h111213141516, D4 = 48'h212223242526;
  localparam logic [47:0] D5 = 48'h313233343536, D6 = 48'h414243444546;

  vec_t        tbl[19];
  logic [47:0] bp_beats[3];
  logic [47:0] got[8];
  bit          got_last[8];

  initial begin
    int idx, n, dones, stall;
    logic [47:0] held;

    // Row i: inputs driven during cycle i; expected values observed in that cycle.
    // Basic burst of 2
    tbl[0]  = mk(1, 2, 0, 1, 1, D1, 0, 0, 0, 0, 0, 48'h0);
    tbl[1]  = mk(0, 0, 0, 1, 1, D1, 1, 0, 0, 1, 0, 48'h0);
    tbl[2]  = mk(0, 0, 0, 1, 1, D2, 1, 1, 0, 1, 0, D1);
    tbl[3]  = mk(0, 0, 0, 1, 1, D2, 0, 1, 1, 1, 0, D2);
    tbl[4]  = mk(0, 0, 0, 0, 1, D2, 0, 0, 0, 0, 1, D2);
    tbl[5]  = mk(0, 0, 0, 0, 1, D2, 0, 0, 0, 0, 0, D2);
    // Flush after 1 of 4 beats, then a burst of 1
    tbl[6]  = mk(1, 4, 0, 0, 1, D3, 0, 0, 0, 0, 0, D2);
    tbl[7]  = mk(0, 0, 0, 1, 1, D3, 1, 0, 0, 1, 0, D2);
    tbl[8]  = mk(0, 0, 1, 0, 1, D4, 1, 1, 0, 1, 0, D3);
    tbl[9]  = mk(1, 1, 0, 0, 1, D4, 0, 0, 0, 0, 0, D3);
    tbl[10] = mk(0, 0, 0, 1, 1, D5, 1, 0, 0, 1, 0, D3);
    tbl[11] = mk(0, 0, 0, 0, 1, D5, 0, 1, 1, 1, 0, D5);
    // Flush in IDLE drops a coincident start
    tbl[12] = mk(1, 2, 1, 0, 1, D5, 0, 0, 0, 0, 1, D5);
    // Zero-length burst; start requests mid-burst are ignored
    tbl[13] = mk(1, 0, 0, 0, 1, D6, 0, 0, 0, 0, 0, D5);
    tbl[14] = mk(1, 5, 0, 1, 1, D6, 1, 0, 0, 1, 0, D5);
    tbl[15] = mk(1, 5, 0, 0, 0, D6, 0, 1, 1, 1, 0, D6);
    tbl[16] = mk(0, 0, 0, 0, 1, D6, 0, 1, 1, 1, 0, D6);
    tbl[17] = mk(0, 0, 0, 0, 1, D6, 0, 0, 0, 0, 1, D6);
    tbl[18] = mk(0, 0, 0, 0, 1, D6, 0, 0, 0, 0, 0, D6);

    rst = 1'b0;
    en1 = 0; cnt1 = '0; flush1 = 0; rts1 = 0; ready1 = 0; ilb1 = '0;
    en2 = 0; cnt2 = '0; flush2 = 0; rts2 = 0; ready2 = 0; ilb2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset out_bytes", out1, '0);
    chk("reset out_valid", valid1, 0);
    chk("reset out_last", last1, 0);
    chk("reset busy", busy1, 0);
    chk("reset done", done1, 0);
    chk("reset rtr", rtr1, 0);
    chk("reset wide out_bytes", out2, '0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      en1 = tbl[i].en; cnt1 = tbl[i].cnt; flush1 = tbl[i].fl;
      rts1 = tbl[i].rts; ready1 = tbl[i].rdy; ilb1 = tbl[i].data;
      #1;
      chk($sformatf("row%0d rtr", i), rtr1, tbl[i].e_rtr);
      chk($sformatf("row%0d out_valid", i), valid1, tbl[i].e_valid);
      chk($sformatf("row%0d out_last", i), last1, tbl[i].e_last);
      chk($sformatf("row%0d busy", i), busy1, tbl[i].e_busy);
      chk($sformatf("row%0d done", i), done1, tbl[i].e_done);
      chk($sformatf("row%0d out_bytes", i), out1, tbl[i].e_bytes);
    end

    // Backpressure: burst of 3, first delivered beat held for 5 cycles
    bp_beats[0] = 48'hA0A1A2A3A4A5;
    bp_beats[1] = 48'hB0B1B2B3B4B5;
    bp_beats[2] = 48'hC0C1C2C3C4C5;
    @(negedge clk);
    en1 = 1; cnt1 = 3; flush1 = 0; rts1 = 0; ready1 = 1;
    idx = 0; n = 0; dones = 0; stall = 0; held = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      en1 = 0;
      rts1 = (idx < 3);
      ilb1 = (idx < 3) ? bp_beats[idx] : 48'hFFFFFFFFFFFF;
      #1;
      if (valid1 && stall < 5) begin
        if (stall == 0) held = out1;
        ready1 = 0;
        stall++;
      end else begin
        ready1 = 1;
      end
      #1;
      if (!ready1) begin
        chk($sformatf("stall%0d rtr", stall), rtr1, 0);
        chk($sformatf("stall%0d out_bytes", stall), out1, held);
      end
      if (rts1 && rtr1) idx++;
      if (valid1 && ready1 && n < 8) begin
        got[n] = out1;
        got_last[n] = last1;
        n++;
      end
      if (done1) dones++;
    end
    chk("bp beat total", n, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp beat%0d data", i), got[i], bp_beats[i]);
      chk($sformatf("bp beat%0d last", i), got_last[i], i == 2);
    end
    chk("bp done pulses", dones, 1);
    chk("bp busy after", busy1, 0);

    // Reset mid-burst while in DRAIN with a beat held
    @(negedge clk);
    en1 = 1; cnt1 = 2; rts1 = 1; ready1 = 1; ilb1 = 48'hDEADBEEF0001;
    @(negedge clk);
    en1 = 0;
    @(negedge clk);
    ilb1 = 48'hDEADBEEF0002;
    @(negedge clk);
    rts1 = 0; ready1 = 0;
    #1;
    chk("drain pre-reset out_valid", valid1, 1);
    chk("drain pre-reset out_last", last1, 1);
    chk("drain pre-reset out_bytes", out1, 48'hDEADBEEF0002);
    rst = 0; flush1 = 1;
    @(negedge clk);
    rst = 1; flush1 = 0; ready1 = 1;
    #1;
    chk("midreset out_bytes", out1, '0);
    chk("midreset out_valid", valid1, 0);
    chk("midreset out_last", last1, 0);
    chk("midreset busy", busy1, 0);
    chk("midreset done", done1, 0);
    chk("midreset rtr", rtr1, 0);

    // Wide-parameter burst of 15 with random rts/ready
    @(negedge clk);
    en2 = 1; cnt2 = 15; rts2 = 0; ready2 = 1;
    idx = 0; n = 0; dones = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      en2 = 0;
      rts2 = (idx < 15) && ($urandom_range(0, 1) == 1);
      ilb2 = rts2 ? mk2(idx) : {144{1'b1}};
      ready2 = ($urandom_range(0, 3) != 0);
      #1;
      if (rts2 && rtr2) idx++;
      if (valid2 && ready2) begin
        chk($sformatf("wide beat%0d data", n), out2, mk2(n));
        chk($sformatf("wide beat%0d last", n), last2, n == 14);
        n++;
      end
      if (done2) dones++;
    end
    chk("wide beat total", n, 15);
    chk("wide done pulses", dones, 1);
    chk("wide busy after", busy2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ilb_stream_reader.md
# ilb_stream_reader

Parametrised input-line-buffer reader for the SoPU. It replaces the fixed 6-byte, two-beat line-buffer latch with a configurable lane count, lane width and burst length. It adds a real ready/valid handshake on both sides, downstream backpressure, a last-beat flag and a synchronous flush. It sits between the input line buffer (ILB) and the SoP datapath.

## Interface

Parameters:
- BYTE_W, 8, width of one lane in bits
- NUM_BYTES, 6, lanes per beat
- BEATS_W, 3, width of the burst-length field; maximum burst is 2^BEATS_W-1 beats

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-low reset
- ilb_read_enable  in  1  start request; sampled only in IDLE
- beat_count  in  BEATS_W  beats in this burst; sampled with ilb_read_enable; 0 is treated as 1
- flush  in  1  synchronous abort; returns the block to IDLE
- sop_to_ilb_rts  in  1  ILB has a beat on ilb_bytes
- sop_to_ilb_rtr  out  1  block accepts a beat this cycle (combinational)
- ilb_bytes  in  NUM_BYTES*BYTE_W  beat data; lane k is bits [k*BYTE_W +: BYTE_W]
- out_bytes  out  NUM_BYTES*BYTE_W  registered beat data, same lane order
- out_valid  out  1  out_bytes holds an unconsumed beat
- out_last  out  1  the beat on out_bytes is the final beat of the burst
- out_ready  in  1  downstream consumes out_bytes when out_valid && out_ready
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the last beat is consumed downstream

## Operation

- States: IDLE, ACTIVE, DRAIN.
- **IDLE**
  - When ilb_read_enable=1, load beats_left = (beat_count==0 ? 1 : beat_count) and go to ACTIVE.
  - Otherwise stay in IDLE.
  - sop_to_ilb_rtr=0.
- **ACTIVE**
  - sop_to_ilb_rtr = !out_valid || out_ready.
  - An ILB transfer occurs when sop_to_ilb_rts && sop_to_ilb_rtr.
  - On a transfer: out_bytes <= ilb_bytes, out_valid <= 1, out_last <= (beats_left==1), beats_left decrements.
  - If beats_left==1 at the transfer, go to DRAIN.
  - A downstream consume with no simultaneous transfer clears out_valid and out_last.
  - A consume and a transfer in the same cycle keep out_valid=1 and load the new beat.
- **DRAIN**
  - sop_to_ilb_rtr=0.
  - When out_valid && out_ready: clear out_valid and out_last, pulse done, go to IDLE.
- ilb_read_enable is ignored outside IDLE; there is no queuing.
- **flush** has priority over every other input in ACTIVE and DRAIN:
  - Next cycle: state=IDLE, out_valid=0, out_last=0, beats_left=0.
  - done is not pulsed.
  - out_bytes keeps its value.
  - flush in IDLE has no effect, and a coincident ilb_read_enable is dropped.
- out_bytes changes only on an ILB transfer or on reset. It is never cleared by state changes.
- Downstream must not rely on out_bytes while out_valid=0.

## Timing

- Reset (rst=0 at posedge):
  - state=IDLE, beats_left=0.
  - out_bytes=0, out_valid=0, out_last=0, done=0, busy=0.
  - sop_to_ilb_rtr=0 combinationally, since the block is in IDLE.
  - Reset wins over flush and over any handshake in the same cycle.
- Start latency: ilb_read_enable at cycle T gives busy=1 and sop_to_ilb_rtr available from cycle T+1.
- Data latency: a transfer at cycle T gives out_valid=1 with the new beat at T+1.
- Throughput: one beat per cycle while sop_to_ilb_rts=1 and out_ready=1.
- Backpressure: with out_ready=0 and out_valid=1, sop_to_ilb_rtr=0 and no beat is lost or overwritten.
- A burst of N beats with both sides always ready:
  - Transfers occur at T+1 .. T+N.
  - The last beat is on out_bytes at T+N+1 with out_last=1.
  - done pulses at T+N+2 if out_ready=1 at T+N+1.
  - busy drops at T+N+2.
- sop_to_ilb_rtr depends combinationally on out_ready and the registered state. There is no combinational path from sop_to_ilb_rts to any output.

## Test plan

- **Basic burst.** Reset, then read_enable with beat_count=2, rts=1 and out_ready=1 throughout, ilb_bytes=0x010203040506 then 0x0A0B0C0D0E0F.
  - Required: two out_valid beats with those values.
  - out_last=1 only on the second beat.
  - done pulses once, then busy=0.
- **Backpressure.** beat_count=3, out_ready held 0 for 5 cycles after the first beat.
  - Required: rtr=0 throughout the stall and out_bytes stable.
  - After release, all 3 beats are delivered in order with none lost.
- **Zero length and ignored start.** beat_count=0.
  - Required: exactly one beat, with out_last=1.
  - A second read_enable pulse mid-burst is ignored, so the beat total stays 1.
- **Flush.** Flush in ACTIVE after 1 of 4 beats.
  - Required: the next cycle has state IDLE, out_valid=0 and no done pulse.
  - A new burst of 1 then completes normally.
- **Reset mid-burst.** rst=0 with out_valid=1 in DRAIN.
  - Required: every output at its reset value the next cycle, including out_bytes=0.
- **Parameter sweep.** BYTE_W=16, NUM_BYTES=9, BEATS_W=4, beat_count=15, rts toggled randomly.
  - Required: all 15 beats are delivered intact, with lane order preserved.
